// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port synchronous RAM (1-cycle registered read) between an
// instruction-fetch port (I, read-only) and a data load/store port (D).
// Every access takes four cycles: IDLE -> ISSUE -> RESP -> DONE.
// Optional build macro ARB_ROUND_ROBIN_EN: when defined, ties are resolved
// round-robin with a 1-bit pointer. When undefined, D always wins over I.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_IDLE  | waiting for a request; winner chosen, RAM address registered
//   S_ISSUE | RAM samples address / write enable
//   S_RESP  | RAM read data valid; captured into owner's rdata, ack set
//   S_DONE  | ack visible for this cycle; requests ignored
module mem_port_arbiter #(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_wren,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          owner
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   w_any_req;
  logic   w_grant_d;
  logic   r_store;

`ifdef ARB_ROUND_ROBIN_EN
  // 1 = I is favoured on the next tie; reset value favours D.
  logic   r_rr_fav_i;
`endif

  // Arbitration and next-state decode.
  always_comb begin
    w_next    = r_state;
    w_any_req = i_req | d_req;
`ifdef ARB_ROUND_ROBIN_EN
    w_grant_d = d_req & (~i_req | ~r_rr_fav_i);
`else
    w_grant_d = d_req;
`endif
    case (r_state)
      S_IDLE:  if (w_any_req) w_next = S_ISSUE;
      S_ISSUE: w_next = S_RESP;
      S_RESP:  w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge Clock or posedge Resetn) begin
    if (Resetn) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Pointer moves only when a transaction is granted, toward the other port.
  always_ff @(posedge Clock or posedge Resetn) begin
    if (Resetn)                            r_rr_fav_i <= 1'b0;
    else if (r_state == S_IDLE && w_any_req) r_rr_fav_i <= w_grant_d;
  end
`endif

  // RAM request registers, read-data capture and ack pulses.
  always_ff @(posedge Clock or posedge Resetn) begin
    if (Resetn) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wren  <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      i_ack     <= 1'b0;
      d_ack     <= 1'b0;
      owner     <= 1'b0;
      r_store   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            owner     <= w_grant_d;
            mem_addr  <= w_grant_d ? d_addr : i_addr;
            mem_wdata <= w_grant_d ? d_wdata : '0;
            mem_wren  <= w_grant_d & d_we;
            r_store   <= w_grant_d & d_we;
          end
        end
        S_ISSUE: mem_wren <= 1'b0;
        S_RESP: begin
          if (owner) begin
            d_ack <= 1'b1;
            // A store has no read data to return; d_rdata keeps its last load.
            if (!r_store) d_rdata <= mem_rdata;
          end else begin
            i_ack   <= 1'b1;
            i_rdata <= mem_rdata;
          end
        end
        S_DONE: begin
          i_ack <= 1'b0;
          d_ack <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: behavioural sync RAM, scoreboard queue of
// expected (port, data) completions, one task per scenario.
module tb_mem_port_arbiter;
  localparam int AW = 16;
  localparam int DW = 16;

  logic          Clock = 1'b0;
  logic          Resetn;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          i_ack;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_ack;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_wren;
  logic [DW-1:0] mem_rdata;
  logic          busy;
  logic          owner;

  typedef struct packed {
    logic          port;   // 0 = I, 1 = D
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

`ifdef ARB_ROUND_ROBIN_EN
  logic tb_fav_i;
`endif

  mem_port_arbiter #(.AW(AW), .DW(DW)) dut (
    .Clock(Clock), .Resetn(Resetn),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren),
    .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
  );

  always #5 Clock = ~Clock;

  // Behavioural single-port RAM with registered read, plus a preload port.
  logic [DW-1:0] ram [0:65535];
  logic          pl_we = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [DW-1:0] pl_data = '0;
  always @(posedge Clock) begin
    if (pl_we)         ram[pl_addr] <= pl_data;
    else if (mem_wren) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] v);
    @(negedge Clock);
    pl_we = 1'b1; pl_addr = a; pl_data = v;
    @(posedge Clock); #1;
    pl_we = 1'b0;
  endtask

  task automatic apply_reset();
    Resetn = 1'b1;
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    repeat (2) @(posedge Clock);
    #1 Resetn = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    tb_fav_i = 1'b0;
`endif
  endtask

  // Waits (bounded) for the next ack; reports cycles taken, which port,
  // cycles with mem_wren high, whether both acks were ever high, timeout.
  task automatic wait_ack(output int cyc, output logic got_d, output int wren_cyc,
                          output logic both, output logic tmo);
    cyc = 0; got_d = 1'b0; wren_cyc = 0; both = 1'b0; tmo = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge Clock); #1;
      if (mem_wren) wren_cyc++;
      if (i_ack && d_ack) both = 1'b1;
      if (i_ack || d_ack) begin
        cyc = n; got_d = d_ack; tmo = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    total++;
    if ({mem_addr, mem_wdata, mem_wren, i_rdata, d_rdata, i_ack, d_ack, owner} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got addr=%h wdata=%h wren=%b irdata=%h drdata=%h iack=%b dack=%b owner=%b, want all 0",
               mem_addr, mem_wdata, mem_wren, i_rdata, d_rdata, i_ack, d_ack, owner);
    end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_fetch();
    int cyc, wc; logic gd, both, tmo; exp_t e;
    e.port = 1'b0; e.data = 16'h1234; sb.push_back(e);
    i_addr = 16'h0005; i_req = 1'b1;
    wait_ack(cyc, gd, wc, both, tmo);
    i_req = 1'b0;
    e = sb.pop_front();
    total++;
    if (tmo !== 1'b0) begin bad++; $display("FAIL fetch_timeout: no ack within 20 cycles"); end
    total++;
    if (cyc !== 3) begin bad++; $display("FAIL fetch_latency: got %0d want 3", cyc); end
    total++;
    if (gd !== e.port) begin bad++; $display("FAIL fetch_port: got %b want %b", gd, e.port); end
    total++;
    if (i_rdata !== e.data) begin bad++; $display("FAIL fetch_data: got %h want %h", i_rdata, e.data); end
    total++;
    if (wc !== 0) begin bad++; $display("FAIL fetch_wren: got %0d wren cycles want 0", wc); end
    @(posedge Clock); #1;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL fetch_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_store_load();
    int cyc, wc; logic gd, both, tmo; exp_t e;
    e.port = 1'b1; e.data = d_rdata === 16'h0000 ? 16'h0000 : 16'hXXXX; e.data = 16'h0000;
    sb.push_back(e);
    d_we = 1'b1; d_addr = 16'h0010; d_wdata = 16'hBEEF; d_req = 1'b1;
    wait_ack(cyc, gd, wc, both, tmo);
    d_req = 1'b0;
    e = sb.pop_front();
    total++;
    if (cyc !== 3 || tmo) begin bad++; $display("FAIL store_latency: got %0d tmo=%b want 3", cyc, tmo); end
    total++;
    if (wc !== 1) begin bad++; $display("FAIL store_wren: got %0d wren cycles want 1", wc); end
    total++;
    if (gd !== e.port || d_rdata !== e.data) begin
      bad++; $display("FAIL store_hold: got port=%b drdata=%h want port=%b drdata=%h", gd, d_rdata, e.port, e.data);
    end
    @(posedge Clock); #1;
    e.port = 1'b1; e.data = 16'hBEEF; sb.push_back(e);
    d_we = 1'b0; d_wdata = 16'h0000; d_req = 1'b1;
    wait_ack(cyc, gd, wc, both, tmo);
    d_req = 1'b0;
    e = sb.pop_front();
    total++;
    if (cyc !== 3 || tmo || gd !== e.port) begin
      bad++; $display("FAIL load_timing: got cyc=%0d port=%b tmo=%b want 3 %b", cyc, gd, tmo, e.port);
    end
    total++;
    if (d_rdata !== e.data) begin bad++; $display("FAIL load_data: got %h want %h", d_rdata, e.data); end
    total++;
    if (i_rdata !== 16'h1234) begin bad++; $display("FAIL irdata_hold: got %h want 1234", i_rdata); end
    @(posedge Clock); #1;
  endtask

  task automatic test_tie();
    int cyc, wc; logic gd, both, tmo, wd; exp_t e;
    apply_reset();
    // Model the grant order: D held for three grants, I held for all four.
    for (int k = 0; k < 4; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
      wd = (k < 3) && !tb_fav_i;
      tb_fav_i = wd;
`else
      wd = (k < 3);
`endif
      e.port = wd; e.data = wd ? 16'h1111 : 16'h2222;
      sb.push_back(e);
    end
    d_we = 1'b0; d_addr = 16'h0030; i_addr = 16'h0040;
    i_req = 1'b1; d_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_ack(cyc, gd, wc, both, tmo);
      if (k == 2) d_req = 1'b0;
      if (k == 3) i_req = 1'b0;
      e = sb.pop_front();
      total++;
      if (tmo || both || cyc !== (k == 0 ? 3 : 4)) begin
        bad++; $display("FAIL tie_timing[%0d]: got cyc=%0d tmo=%b both=%b want cyc=%0d", k, cyc, tmo, both, (k == 0 ? 3 : 4));
      end
      total++;
      if (gd !== e.port || (gd ? d_rdata : i_rdata) !== e.data) begin
        bad++; $display("FAIL tie_grant[%0d]: got port=%b data=%h want port=%b data=%h",
                        k, gd, (gd ? d_rdata : i_rdata), e.port, e.data);
      end
    end
    @(posedge Clock); #1;
  endtask

  task automatic test_back_to_back();
    int cyc, wc; logic gd, both, tmo; exp_t e;
    i_addr = 16'h0050; i_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      e.port = 1'b0; e.data = 16'hA000 + 16'(k); sb.push_back(e);
      wait_ack(cyc, gd, wc, both, tmo);
      if (k == 2) i_req = 1'b0;
      else        i_addr = i_addr + 16'd1;
      e = sb.pop_front();
      total++;
      if (tmo || cyc !== (k == 0 ? 3 : 4) || gd !== e.port) begin
        bad++; $display("FAIL b2b_timing[%0d]: got cyc=%0d port=%b tmo=%b want cyc=%0d port=0", k, cyc, gd, tmo, (k == 0 ? 3 : 4));
      end
      total++;
      if (i_rdata !== e.data) begin bad++; $display("FAIL b2b_data[%0d]: got %h want %h", k, i_rdata, e.data); end
    end
    @(posedge Clock); #1;
  endtask

  task automatic test_reset_mid();
    int cyc, wc, acks; logic gd, both, tmo; exp_t e;
    d_we = 1'b1; d_addr = 16'h0020; d_wdata = 16'hAAAA; d_req = 1'b1;
    @(posedge Clock); #1;
    total++;
    if (mem_wren !== 1'b1 || busy !== 1'b1) begin
      bad++; $display("FAIL rst_mid_issue: got wren=%b busy=%b want 1 1", mem_wren, busy);
    end
    Resetn = 1'b1;
    #1;
    total++;
    if ({mem_addr, mem_wdata, mem_wren, i_rdata, d_rdata, i_ack, d_ack, owner, busy} !== '0) begin
      bad++; $display("FAIL rst_mid_outputs: got addr=%h wdata=%h wren=%b irdata=%h drdata=%h iack=%b dack=%b owner=%b busy=%b want all 0",
                      mem_addr, mem_wdata, mem_wren, i_rdata, d_rdata, i_ack, d_ack, owner, busy);
    end
    @(posedge Clock); #1;
    Resetn = 1'b0; d_req = 1'b0; d_we = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    tb_fav_i = 1'b0;
`endif
    acks = 0;
    for (int n = 0; n < 5; n++) begin
      @(posedge Clock); #1;
      if (i_ack || d_ack) acks++;
    end
    total++;
    if (acks !== 0) begin bad++; $display("FAIL rst_mid_noack: got %0d acks want 0", acks); end
    e.port = 1'b1; e.data = 16'hBEEF; sb.push_back(e);
    d_addr = 16'h0010; d_req = 1'b1;
    wait_ack(cyc, gd, wc, both, tmo);
    d_req = 1'b0;
    e = sb.pop_front();
    total++;
    if (tmo || cyc !== 3 || gd !== e.port || d_rdata !== e.data) begin
      bad++; $display("FAIL rst_mid_recover: got cyc=%0d port=%b data=%h tmo=%b want 3 %b %h",
                      cyc, gd, d_rdata, tmo, e.port, e.data);
    end
    @(posedge Clock); #1;
  endtask

  task automatic test_drop();
    int cyc, wc, acks; logic gd, both, tmo; exp_t e;
    e.port = 1'b1; e.data = 16'h5A5A; sb.push_back(e);
    d_we = 1'b0; d_addr = 16'h0060; d_req = 1'b1;
    @(posedge Clock); #1;
    @(posedge Clock); #1;
    d_req = 1'b0;
    d_addr = 16'h0010;
    wait_ack(cyc, gd, wc, both, tmo);
    e = sb.pop_front();
    total++;
    if (tmo || cyc !== 1 || gd !== e.port || d_rdata !== e.data) begin
      bad++; $display("FAIL drop_ack: got cyc=%0d port=%b data=%h tmo=%b want 1 %b %h",
                      cyc, gd, d_rdata, tmo, e.port, e.data);
    end
    acks = 0;
    for (int n = 0; n < 4; n++) begin
      @(posedge Clock); #1;
      if (i_ack || d_ack) acks++;
    end
    total++;
    if (acks !== 0 || busy !== 1'b0) begin
      bad++; $display("FAIL drop_idle: got extra_acks=%0d busy=%b want 0 0", acks, busy);
    end
  endtask

  initial begin
    Resetn = 1'b1;
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    preload(16'h0005, 16'h1234);
    preload(16'h0030, 16'h1111);
    preload(16'h0040, 16'h2222);
    preload(16'h0050, 16'hA000);
    preload(16'h0051, 16'hA001);
    preload(16'h0052, 16'hA002);
    preload(16'h0060, 16'h5A5A);
    test_reset();
    test_fetch();
    test_store_load();
    test_tie();
    test_back_to_back();
    test_reset_mid();
    test_drop();
    total++;
    if (sb.size() !== 0) begin bad++; $display("FAIL scoreboard_empty: got %0d left want 0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
